// File: rtl/mask_encoder_8x3.sv
// mask_encoder_8x3: serialises an 8-bit multi-hot register mask into a stream
// of 3-bit register indices, one per valid/ready handshake, in fixed priority
// order. Bit k of the mask maps to index k, matching the 3x8 select decoder.
module mask_encoder_8x3 #(
  // 0: lowest set index first, 1: highest set index first.
  parameter bit PRIORITY_HIGH = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       load_valid,
  output logic       load_ready,
  input  logic [7:0] mask,
  output logic       idx_valid,
  input  logic       idx_ready,
  output logic [2:0] idx,
  output logic       idx_last,
  output logic [3:0] remaining,
  output logic       busy
);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StDrain = 1'b1;

  logic [0:0] state_q, state_d;
  logic [7:0] pending_q, pending_d;

  // Number of set bits in a mask, 0..8.
  function automatic logic [3:0] popcount8(input logic [7:0] m);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + {3'd0, m[i]};
    end
    return cnt;
  endfunction

  // Position of the lowest set bit; 0 when the mask is empty.
  function automatic logic [2:0] lowest_set(input logic [7:0] m);
    logic [2:0] pos;
    pos = 3'd0;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) begin
        pos = 3'(i);
      end
    end
    return pos;
  endfunction

  // Position of the highest set bit; 0 when the mask is empty.
  function automatic logic [2:0] highest_set(input logic [7:0] m);
    logic [2:0] pos;
    pos = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        pos = 3'(i);
      end
    end
    return pos;
  endfunction

  logic       draining;
  logic [3:0] pend_cnt;
  logic [2:0] sel_idx;
  logic       sel_last;
  logic       idx_fire;
  logic       load_fire;

  assign draining = (state_q == StDrain);
  assign pend_cnt = popcount8(pending_q);
  assign sel_idx  = PRIORITY_HIGH ? highest_set(pending_q) : lowest_set(pending_q);
  assign sel_last = (pend_cnt == 4'd1);

  // Outputs that depend only on registered state; idx fields read 0 when idle.
  always_comb begin
    idx_valid = draining;
    busy      = draining;
    idx       = draining ? sel_idx : 3'd0;
    idx_last  = draining & sel_last;
    remaining = draining ? pend_cnt : 4'd0;
  end

  // Accept a new mask when idle, or on the final handshake so drains chain
  // back-to-back; flush always blocks loads for its cycle.
  always_comb begin
    load_ready = 1'b0;
    if (!flush) begin
      if (!draining) begin
        load_ready = 1'b1;
      end else begin
        load_ready = idx_last & idx_ready;
      end
    end
  end

  assign idx_fire  = idx_valid & idx_ready;
  assign load_fire = load_valid & load_ready;

  // Next-state: flush aborts, a load replaces pending, a handshake retires one bit.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    if (flush) begin
      // Any coincident handshake is deliberately dropped.
      state_d   = StIdle;
      pending_d = 8'd0;
    end else begin
      if (idx_fire) begin
        pending_d[sel_idx] = 1'b0;
        if (sel_last) begin
          state_d = StIdle;
        end
      end
      if (load_fire) begin
        // A zero mask is consumed without producing any index.
        pending_d = mask;
        state_d   = (mask != 8'd0) ? StDrain : StIdle;
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      pending_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: tb/tb_mask_encoder_8x3.sv
// Self-checking bench for mask_encoder_8x3: one instance per priority order,
// both driven by the same stimulus.
module tb_mask_encoder_8x3;

  logic       clk = 1'b0;
  logic       reset, flush, load_valid, idx_ready;
  logic [7:0] mask;

  logic       lr_lo, iv_lo, il_lo, busy_lo;
  logic [2:0] idx_lo;
  logic [3:0] rem_lo;
  logic       lr_hi, iv_hi, il_hi, busy_hi;
  logic [2:0] idx_hi;
  logic [3:0] rem_hi;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mask_encoder_8x3 #(.PRIORITY_HIGH(1'b0)) u_lo (
    .clk(clk), .reset(reset), .flush(flush), .load_valid(load_valid), .load_ready(lr_lo),
    .mask(mask), .idx_valid(iv_lo), .idx_ready(idx_ready), .idx(idx_lo), .idx_last(il_lo),
    .remaining(rem_lo), .busy(busy_lo)
  );

  mask_encoder_8x3 #(.PRIORITY_HIGH(1'b1)) u_hi (
    .clk(clk), .reset(reset), .flush(flush), .load_valid(load_valid), .load_ready(lr_hi),
    .mask(mask), .idx_valid(iv_hi), .idx_ready(idx_ready), .idx(idx_hi), .idx_last(il_hi),
    .remaining(rem_hi), .busy(busy_hi)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge; inputs change here, outputs sampled #1 later.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    check({tag, " lo load_ready"}, int'(lr_lo), 1);
    check({tag, " lo idx_valid"}, int'(iv_lo), 0);
    check({tag, " lo idx"}, int'(idx_lo), 0);
    check({tag, " lo idx_last"}, int'(il_lo), 0);
    check({tag, " lo remaining"}, int'(rem_lo), 0);
    check({tag, " lo busy"}, int'(busy_lo), 0);
    check({tag, " hi idx_valid"}, int'(iv_hi), 0);
    check({tag, " hi busy"}, int'(busy_hi), 0);
  endtask

  typedef struct {
    logic [7:0] m;
    int         cnt;
    int         first_lo;
    int         first_hi;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{m: 8'hA4, cnt: 3, first_lo: 2, first_hi: 7};
    vecs[1] = '{m: 8'h01, cnt: 1, first_lo: 0, first_hi: 0};
    vecs[2] = '{m: 8'h80, cnt: 1, first_lo: 7, first_hi: 7};
    vecs[3] = '{m: 8'hFF, cnt: 8, first_lo: 0, first_hi: 7};
    vecs[4] = '{m: 8'h3C, cnt: 4, first_lo: 2, first_hi: 5};
    vecs[5] = '{m: 8'h5A, cnt: 4, first_lo: 1, first_hi: 6};
    vecs[6] = '{m: 8'h81, cnt: 2, first_lo: 0, first_hi: 7};

    reset = 1'b1; flush = 1'b0; load_valid = 1'b0; idx_ready = 1'b0; mask = 8'h00;
    cyc(); cyc();
    reset = 1'b0;
    #1 check_idle("reset");

    // Detailed drain of 0xA4 with idx_ready held high.
    cyc(); load_valid = 1'b1; mask = 8'hA4; idx_ready = 1'b1;
    #1 check("a4 load_ready", int'(lr_lo), 1);
    cyc(); load_valid = 1'b0;
    #1 check("a4 c0 idx", int'(idx_lo), 2); check("a4 c0 rem", int'(rem_lo), 3);
    check("a4 c0 last", int'(il_lo), 0); check("a4 c0 hi idx", int'(idx_hi), 7);
    check("a4 c0 load_ready", int'(lr_lo), 0);
    cyc();
    #1 check("a4 c1 idx", int'(idx_lo), 5); check("a4 c1 rem", int'(rem_lo), 2);
    check("a4 c1 last", int'(il_lo), 0); check("a4 c1 hi idx", int'(idx_hi), 5);
    cyc();
    #1 check("a4 c2 idx", int'(idx_lo), 7); check("a4 c2 rem", int'(rem_lo), 1);
    check("a4 c2 last", int'(il_lo), 1); check("a4 c2 hi idx", int'(idx_hi), 2);
    check("a4 c2 hi last", int'(il_hi), 1); check("a4 c2 load_ready", int'(lr_lo), 1);
    cyc();
    #1 check_idle("a4 done");

    // Table: drain each mask with ready high, checking first/last index and length.
    foreach (vecs[v]) begin
      int cycles;
      int last_lo;
      int last_hi;
      cyc(); load_valid = 1'b1; mask = vecs[v].m; idx_ready = 1'b1;
      #1 check("tbl load_ready", int'(lr_lo), 1);
      cyc(); load_valid = 1'b0;
      #1 check("tbl first lo", int'(idx_lo), vecs[v].first_lo);
      check("tbl first hi", int'(idx_hi), vecs[v].first_hi);
      check("tbl first rem", int'(rem_lo), vecs[v].cnt);
      check("tbl first rem hi", int'(rem_hi), vecs[v].cnt);
      cycles = 0; last_lo = -1; last_hi = -1;
      while (busy_lo && cycles < 12) begin
        if (il_lo) last_lo = int'(idx_lo);
        if (il_hi) last_hi = int'(idx_hi);
        cycles++;
        cyc();
        #1;
      end
      check("tbl drain cycles", cycles, vecs[v].cnt);
      check("tbl last lo", last_lo, vecs[v].first_hi);
      check("tbl last hi", last_hi, vecs[v].first_lo);
      check("tbl hi busy end", int'(busy_hi), 0);
    end

    // Full mask with ready toggling 0,1,0,1: each index held across its stall.
    cyc(); load_valid = 1'b1; mask = 8'hFF; idx_ready = 1'b1;
    cyc(); load_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      idx_ready = (i % 2) == 1;
      #1 check("ff hi idx", int'(idx_hi), 7 - i / 2);
      check("ff lo idx", int'(idx_lo), i / 2);
      check("ff rem", int'(rem_hi), 8 - i / 2);
      check("ff hi last", int'(il_hi), (i / 2 == 7) ? 1 : 0);
      check("ff valid", int'(iv_hi), 1);
      cyc();
    end
    idx_ready = 1'b1;
    #1 check_idle("ff done");

    // Zero mask is consumed silently.
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1; mask = 8'h00;
      #1 check_idle("zero");
      cyc();
    end
    load_valid = 1'b0;
    #1 check_idle("zero after");

    // Back-to-back: 0x01 then 0x90 accepted on the final handshake, no bubble.
    load_valid = 1'b1; mask = 8'h01; idx_ready = 1'b1;
    cyc(); mask = 8'h90;
    #1 check("b2b c0 idx", int'(idx_lo), 0); check("b2b c0 last", int'(il_lo), 1);
    check("b2b c0 load_ready", int'(lr_lo), 1); check("b2b c0 hi load_ready", int'(lr_hi), 1);
    cyc();
    #1 check("b2b c1 idx", int'(idx_lo), 4); check("b2b c1 valid", int'(iv_lo), 1);
    check("b2b c1 rem", int'(rem_lo), 2); check("b2b c1 load_ready", int'(lr_lo), 0);
    check("b2b c1 hi idx", int'(idx_hi), 7);
    cyc(); load_valid = 1'b0;
    #1 check("b2b c2 idx", int'(idx_lo), 7); check("b2b c2 last", int'(il_lo), 1);
    check("b2b c2 hi idx", int'(idx_hi), 4);
    cyc();
    #1 check_idle("b2b done");

    // Flush after first handshake of 0x0F, coincident with idx_ready.
    load_valid = 1'b1; mask = 8'h0F; idx_ready = 1'b1;
    cyc(); load_valid = 1'b0;
    #1 check("fl c0 idx", int'(idx_lo), 0);
    cyc(); flush = 1'b1;
    #1 check("fl c1 idx", int'(idx_lo), 1); check("fl c1 load_ready", int'(lr_lo), 0);
    check("fl c1 hi load_ready", int'(lr_hi), 0);
    cyc(); flush = 1'b0;
    #1 check_idle("fl after");

    // Flush in idle only blocks the load.
    flush = 1'b1; load_valid = 1'b1; mask = 8'h55;
    #1 check("fl idle load_ready", int'(lr_lo), 0);
    cyc(); flush = 1'b0; load_valid = 1'b0;
    #1 check_idle("fl idle after");

    // Reset mid-drain of 0x3C, then a fresh load of 0x02.
    load_valid = 1'b1; mask = 8'h3C; idx_ready = 1'b1;
    cyc(); load_valid = 1'b0;
    #1 check("rst c0 idx", int'(idx_lo), 2);
    cyc(); reset = 1'b1;
    cyc(); reset = 1'b0;
    #1 check_idle("rst after");
    load_valid = 1'b1; mask = 8'h02;
    cyc(); load_valid = 1'b0;
    #1 check("rst new idx", int'(idx_lo), 1); check("rst new last", int'(il_lo), 1);
    check("rst new hi idx", int'(idx_hi), 1); check("rst new rem", int'(rem_lo), 1);
    cyc();
    #1 check_idle("rst new done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
